// File: rtl/uart_stim_pkg.sv
// Shared types and helpers for the uart_stim_tx stimulus transmitter.
package uart_stim_pkg;

  localparam int UART_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Clock cycles per bit, truncated.
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_stim_fifo.sv
// Single-clock power-of-two FIFO; pointers carry an extra wrap bit so
// full/empty/count fall straight out of the pointer pair.
module uart_stim_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  input  logic                   rd_en,
  output logic [W-1:0]           rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_stim_fifo: DEPTH must be a power of two >= 2");
  end

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW:0]             wptr_q, wptr_d;
  logic [AW:0]             rptr_q, rptr_d;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_en) begin
      mem_d[wptr_q[AW-1:0]] = wr_data;
      wptr_d                = wptr_q + PTR_ONE;
    end
    if (rd_en) rptr_d = rptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) mem_q <= mem_d;

  assign rd_data = mem_q[rptr_q[AW-1:0]];
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count   = wptr_q - rptr_q;

endmodule

// File: rtl/uart_stim_tx.sv
// Bench-side 8N1 UART transmitter fed from a byte FIFO.
// Define UART_STIM_PARITY_EN for 8E1 frames (even parity bit before stop).
module uart_stim_tx
  import uart_stim_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  i_data,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic                        o_uart_tx,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_level,
  output logic                        o_done
);

  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD);
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int BW  = $clog2(UART_BITS);

  if (DIV < 2) begin : g_bad_div
    $error("uart_stim_tx: CLK_FREQ_HZ / BAUD must be at least 2");
  end

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [UART_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
`ifdef UART_STIM_PARITY_EN
  logic                 par_q, par_d;
`endif

  logic                 push, pop, baud_end;
  logic                 fifo_full, fifo_empty;
  logic [7:0]           fifo_data;

  assign o_ready = !rst && !fifo_full;
  assign push    = i_valid && o_ready;

  uart_stim_fifo #(.DEPTH(FIFO_DEPTH), .W(UART_BITS)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (i_data),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (o_level)
  );

  assign baud_end = (baud_q == CW'(DIV - 1));

  // tx_d always reflects the level of the state being entered, so the
  // line is a clean flop output that changes exactly on bit boundaries.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef UART_STIM_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != IDLE) baud_d = baud_end ? '0 : baud_q + CW'(1);
    case (state_q)
      IDLE: if (!fifo_empty) begin
        state_d = START;
        pop     = 1'b1;
        tx_d    = 1'b0;
      end
      START: if (baud_end) begin
        state_d = DATA;
        bit_d   = '0;
        tx_d    = shift_q[0];
      end
      DATA: if (baud_end) begin
        if (bit_q == BW'(UART_BITS - 1)) begin
`ifdef UART_STIM_PARITY_EN
          state_d = PARITY;
          tx_d    = par_q;
`else
          state_d = STOP;
          tx_d    = 1'b1;
`endif
        end else begin
          bit_d   = bit_q + BW'(1);
          shift_d = {1'b0, shift_q[UART_BITS-1:1]};
          tx_d    = shift_q[1];
        end
      end
`ifdef UART_STIM_PARITY_EN
      PARITY: if (baud_end) begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
`endif
      STOP: if (baud_end) begin
        if (!fifo_empty) begin
          state_d = START;
          pop     = 1'b1;
          tx_d    = 1'b0;
        end else begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    if (pop) begin
      shift_d = fifo_data;
`ifdef UART_STIM_PARITY_EN
      par_d   = ^fifo_data;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_STIM_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_STIM_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign o_uart_tx = tx_q;
  assign o_done    = (state_q == STOP) && baud_end;
  assign o_busy    = (state_q != IDLE) || (o_level != '0);

endmodule
